// File: rtl/r2fft_pkg.sv
// Shared types for the radix-2 FFT core control path: core status encoding
// and the frame sequencer state set.
package r2fft_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    INPUT_STREAM  = 3'd1,
    FULL_BUFFER   = 3'd2,
    RUN_FFT       = 3'd3,
    DONE          = 3'd4
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FFT,
    S_READ,
    S_DRAIN,
    S_FIN,
    S_WAIT_CLEAR
  } seq_state_t;

endpackage

// File: rtl/r2fft_stream_fifo2.sv
// Two-entry first-word-fall-through register FIFO; entry 0 is always the head.
module r2fft_stream_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: a lone head is replaced, a full pair shifts.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/r2fft_frame_sequencer.sv
// Frame sequencer for the radix-2 FFT core: sequences run/fin/autorun and
// unloads each finished frame from the DMA read bus as a valid/ready stream.
module r2fft_frame_sequencer
  import r2fft_pkg::*;
#(
  parameter  int unsigned FFT_LENGTH = 1024,
  parameter  int unsigned FFT_DW     = 16,
  localparam int unsigned FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              autorun_cfg,
  input  logic              start,
  input  logic [2:0]        fft_status,
  input  logic [7:0]        fft_bfpexp,
  output logic              fft_autorun,
  output logic              fft_run,
  output logic              fft_fin,
  output logic              dmaact,
  output logic [FFT_N-1:0]  dmaa,
  input  logic [FFT_DW-1:0] dmadr_real,
  input  logic [FFT_DW-1:0] dmadr_imag,
  output logic              ostream_valid,
  input  logic              ostream_ready,
  output logic [FFT_DW-1:0] ostream_real,
  output logic [FFT_DW-1:0] ostream_imag,
  output logic [FFT_N-1:0]  ostream_index,
  output logic              ostream_last,
  output logic [7:0]        ostream_bfpexp,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int unsigned FW = 2*FFT_DW + FFT_N + 1;
  localparam logic [FFT_N-1:0] LAST_BIN = '1;

  seq_state_t       state, state_nxt;
  logic             start_pend;
  logic             run_done;
  logic             rd_pend;
  logic [FFT_N-1:0] rd_addr;
  logic [1:0]       fifo_count;
  logic [FW-1:0]    fifo_din;
  logic [FW-1:0]    fifo_dout;
  logic             pop;
  logic [2:0]       occupancy;

  assign ostream_valid = (fifo_count != 2'd0);
  assign pop           = ostream_valid && ostream_ready;
  assign occupancy     = {1'b0, fifo_count} + {2'b00, rd_pend};
  assign fifo_din      = {(rd_addr == LAST_BIN), rd_addr, dmadr_imag, dmadr_real};
  assign {ostream_last, ostream_index, ostream_imag, ostream_real} = fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (enable) state_nxt = S_WAIT_FFT;
      S_WAIT_FFT:   if (fft_status == DONE) state_nxt = S_READ;
      S_READ:       if (dmaact && (dmaa == LAST_BIN)) state_nxt = S_DRAIN;
      S_DRAIN:      if (!rd_pend && (fifo_count == 2'd0)) state_nxt = S_FIN;
      S_FIN:        state_nxt = S_WAIT_CLEAR;
      S_WAIT_CLEAR: if (fft_status != DONE) state_nxt = enable ? S_WAIT_FFT : S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Credit counts the slot freed by a same-cycle pop so ready=1 sustains one
  // read per cycle while entries plus in-flight never exceed two.
  always_comb begin
    dmaact  = 1'b0;
    fft_run = 1'b0;
    fft_fin = 1'b0;
    busy    = (state != S_IDLE);
    unique case (state)
      S_WAIT_FFT: fft_run = (fft_status == FULL_BUFFER) && start_pend && !fft_autorun && !run_done;
      S_READ:     dmaact  = (occupancy < (3'd2 + {2'b00, pop}));
      S_FIN:      fft_fin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fft_autorun    <= 1'b0;
      start_pend     <= 1'b0;
      run_done       <= 1'b0;
      rd_pend        <= 1'b0;
      rd_addr        <= '0;
      dmaa           <= '0;
      ostream_bfpexp <= '0;
      frame_count    <= '0;
    end else begin
      if ((state == S_IDLE) || (state == S_WAIT_CLEAR)) fft_autorun <= autorun_cfg;

      if (start)        start_pend <= 1'b1;
      else if (fft_run) start_pend <= 1'b0;

      if (fft_status != FULL_BUFFER) run_done <= 1'b0;
      else if (fft_run)              run_done <= 1'b1;

      rd_pend <= dmaact;
      if (dmaact) rd_addr <= dmaa;

      if ((state == S_WAIT_FFT) && (fft_status == DONE)) begin
        ostream_bfpexp <= fft_bfpexp;
        dmaa           <= '0;
      end else if (dmaact) begin
        dmaa <= dmaa + 1'b1;
      end

      if (fft_fin) frame_count <= frame_count + 16'd1;
    end
  end

  r2fft_stream_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_r2fft_frame_sequencer.sv
// Randomized bench for r2fft_frame_sequencer: a behavioural core memory feeds the
// DMA bus and each frame's stream is compared against the bins in order.
module tb_r2fft_frame_sequencer;
  import r2fft_pkg::*;

  localparam int unsigned L  = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          autorun_cfg = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    fft_status = 3'd0;
  logic [7:0]    fft_bfpexp = 8'd0;
  logic          fft_autorun, fft_run, fft_fin, dmaact;
  logic [N-1:0]  dmaa;
  logic [DW-1:0] dmadr_real = '0;
  logic [DW-1:0] dmadr_imag = '0;
  logic          ostream_valid;
  logic          ostream_ready = 1'b1;
  logic [DW-1:0] ostream_real, ostream_imag;
  logic [N-1:0]  ostream_index;
  logic          ostream_last;
  logic [7:0]    ostream_bfpexp;
  logic          busy;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  r2fft_frame_sequencer #(
    .FFT_LENGTH(L),
    .FFT_DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .autorun_cfg(autorun_cfg), .start(start),
    .fft_status(fft_status), .fft_bfpexp(fft_bfpexp), .fft_autorun(fft_autorun),
    .fft_run(fft_run), .fft_fin(fft_fin), .dmaact(dmaact), .dmaa(dmaa),
    .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag), .ostream_valid(ostream_valid),
    .ostream_ready(ostream_ready), .ostream_real(ostream_real), .ostream_imag(ostream_imag),
    .ostream_index(ostream_index), .ostream_last(ostream_last),
    .ostream_bfpexp(ostream_bfpexp), .busy(busy), .frame_count(frame_count)
  );

  // Core result memory: one registered read per dmaact.
  logic [31:0] mem [L];
  always @(posedge clk) begin
    if (dmaact) begin
      dmadr_real <= mem[dmaa][15:0];
      dmadr_imag <= mem[dmaa][31:16];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int beat     = 0;
  int issued   = 0;
  int popped   = 0;
  int runs     = 0;
  int fins     = 0;
  int last_run_cyc = -1;
  int first_hs = -1;
  int last_hs  = -1;
  logic              stall_prev = 1'b0;
  logic [2*DW+N:0]   snap = '0;
  logic [15:0]       exp_count = '0;
  logic [7:0]        exp_exp = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_no);
    end
  endtask

  task automatic sample();
    logic [2*DW+N:0] cur;
    cur = {ostream_last, ostream_index, ostream_imag, ostream_real};
    if (fft_run) begin runs++; last_run_cyc = cyc_no; end
    if (fft_fin) fins++;
    if (dmaact)  issued++;
    if (stall_prev) begin
      check_eq("valid_hold", ostream_valid, 1);
      check_eq("stall_data", cur, snap);
    end
    if (ostream_valid && ostream_ready) begin
      check_eq("real",   ostream_real,   mem[beat][15:0]);
      check_eq("imag",   ostream_imag,   mem[beat][31:16]);
      check_eq("index",  ostream_index,  beat);
      check_eq("last",   ostream_last,   beat == L-1);
      check_eq("bfpexp", ostream_bfpexp, exp_exp);
      popped++;
      if (first_hs < 0) first_hs = cyc_no;
      last_hs = cyc_no;
      beat = (beat + 1) % L;
    end
    check_eq("outstanding_le2", (issued - popped) <= 2, 1);
    stall_prev = ostream_valid && !ostream_ready;
    snap = cur;
  endtask

  task automatic cycle();
    #1;
    sample();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic clear_model();
    beat = 0; issued = 0; popped = 0; stall_prev = 1'b0; exp_count = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; start = 1'b0; fft_status = IDLE; ostream_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    clear_model();
    #1;
    check_eq("rst_valid", ostream_valid, 0);
    check_eq("rst_dmaact", dmaact, 0);
    check_eq("rst_run", fft_run, 0);
    check_eq("rst_fin", fft_fin, 0);
    check_eq("rst_autorun", fft_autorun, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", frame_count, 0);
    check_eq("rst_dmaa", dmaa, 0);
    check_eq("rst_bfpexp", ostream_bfpexp, 0);
    check_eq("rst_real", ostream_real, 0);
    @(negedge clk);
    cyc_no++;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. drop_at<0: never drop enable.
  task automatic run_frame(input logic [7:0] e, input int ready_mode, input int drop_at);
    int base_pop, base_fin;
    for (int i = 0; i < L; i++) mem[i] = $urandom;
    exp_exp = e; fft_bfpexp = e; fft_status = DONE;
    base_pop = popped; base_fin = fins; first_hs = -1;
    for (int i = 0; i < 400 && fins == base_fin; i++) begin
      case (ready_mode)
        0:       ostream_ready = 1'b1;
        1:       ostream_ready = (i % 4 == 0) || (i % 4 == 3);
        default: ostream_ready = 1'($urandom_range(0, 1));
      endcase
      if (drop_at >= 0 && (popped - base_pop) >= drop_at) enable = 1'b0;
      cycle();
    end
    exp_count = exp_count + 16'(fins - base_fin);
    check_eq("fin_pulses", fins - base_fin, 1);
    check_eq("beats", popped - base_pop, L);
    check_eq("frame_count", frame_count, exp_count);
    if (ready_mode == 0) check_eq("throughput", last_hs - first_hs, L - 1);
    fft_status = IDLE; ostream_ready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    int r0, base, i0, f0, bp;
    @(negedge clk);

    // Autorun frame, exponent -3
    do_reset();
    autorun_cfg = 1'b1; enable = 1'b1;
    cycle();
    r0 = runs;
    run_frame(8'hFD, 0, -1);
    check_eq("autorun_on", fft_autorun, 1);
    check_eq("no_run_autorun", runs - r0, 0);

    // Manual run pulse
    do_reset();
    autorun_cfg = 1'b0; enable = 1'b1;
    cycle();
    cycle();
    check_eq("autorun_off", fft_autorun, 0);
    r0 = runs; base = cyc_no; fft_status = FULL_BUFFER;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      cycle();
    end
    start = 1'b0;
    check_eq("run_pulses", runs - r0, 1);
    check_eq("run_cycle", last_run_cyc - base, 5);
    fft_status = IDLE;
    cycle();
    r0 = runs; fft_status = FULL_BUFFER;
    repeat (10) cycle();
    check_eq("run_none", runs - r0, 0);
    fft_status = IDLE;
    cycle();

    // Stall patterns
    run_frame(8'($urandom), 1, -1);
    run_frame(8'($urandom), 2, -1);

    // Enable dropped mid-frame
    run_frame(8'($urandom), 0, 5);
    check_eq("idle_busy", busy, 0);
    i0 = issued; fft_status = DONE;
    repeat (10) cycle();
    check_eq("no_frame2", issued - i0, 0);
    check_eq("still_idle", busy, 0);
    fft_status = IDLE;
    cycle();

    // Reset mid-frame
    enable = 1'b1;
    cycle();
    for (int i = 0; i < L; i++) mem[i] = $urandom;
    exp_exp = 8'($urandom); fft_bfpexp = exp_exp; fft_status = DONE;
    bp = popped; f0 = fins;
    for (int i = 0; i < 200 && (popped - bp) < 7; i++) cycle();
    check_eq("reach_beat7", popped - bp, 7);
    rst = 1'b1;
    cycle();
    rst = 1'b0; enable = 1'b0; fft_status = IDLE;
    clear_model();
    #1;
    check_eq("rst_mid_valid", ostream_valid, 0);
    check_eq("rst_mid_dmaact", dmaact, 0);
    check_eq("rst_mid_count", frame_count, 0);
    @(negedge clk);
    cyc_no++;
    repeat (20) cycle();
    check_eq("rst_no_fin", fins - f0, 0);
    check_eq("rst_count_hold", frame_count, 0);

    // Counter wrap with back-to-back frames
    enable = 1'b1;
    cycle();
    force dut.frame_count = 16'hFFFE;
    cycle();
    release dut.frame_count;
    cycle();
    check_eq("preset", frame_count, 16'hFFFE);
    exp_count = 16'hFFFE;
    run_frame(8'($urandom), 0, -1);
    run_frame(8'($urandom), 0, -1);
    check_eq("wrap", frame_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc_no);
    $fatal(1);
  end

endmodule
